// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//
// Shared definitions for the PS/2 scan-code receiver:
//   ps2_state_t    - frame deframer states (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK      - key-release prefix byte (F0)
//   PS2_EXT        - extended-key prefix byte (E0)
//   odd_parity_ok  - frame parity check (data bits plus parity bit must hold
//                    an odd number of ones)
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity across the eight data bits and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data_bits,
                                         input logic       parity_bit);
    return ^{data_bits, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ---------------------------------------------------------------------------
// ps2_sync_filter
//
// Brings the asynchronous PS/2 clock and data lines into the clk domain and
// reports falling edges of the PS/2 clock.
//
// Optional feature (macro PS2_GLITCH_FILTER_EN):
//   When defined, the synchronised kb_clk passes through a debounce filter
//   that only moves its output after FILTER_LEN consecutive identical
//   samples. kb_data is delayed by FILTER_LEN stages so the bit sampled on
//   the filtered edge is the same bit that was present on the raw edge.
//   When undefined, the synchronised kb_clk feeds the edge detector directly.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   kb_clk     in   PS/2 clock (asynchronous)
//   kb_data    in   PS/2 data (asynchronous)
//   fall_edge  out  one-cycle strobe on a kb_clk falling edge
//   data_s     out  synchronised (and aligned) kb_data, valid with fall_edge
// ---------------------------------------------------------------------------
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic kb_clk,
  input  logic kb_data,
  output logic fall_edge,
  output logic data_s
);

  // Two-flop synchronisers; reset to 1 because an idle PS/2 bus is high.
  logic clk_s1_q,  clk_s1_d;
  logic clk_s2_q,  clk_s2_d;
  logic data_s1_q, data_s1_d;
  logic data_s2_q, data_s2_d;

  always_comb begin
    clk_s1_d  = kb_clk;
    clk_s2_d  = clk_s1_q;
    data_s1_d = kb_data;
    data_s2_d = data_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
    end
  end

  // Clock level seen by the edge detector, and the data bit aligned to it.
  logic clk_level;
  logic data_level;

`ifdef PS2_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_q,     filt_d;

  // Count samples that disagree with the current output; any agreeing
  // sample restarts the count, so only an unbroken run of FILTER_LEN
  // samples moves the output.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_d     = filt_q;
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == CW'(FILTER_LEN - 1)) begin
      filt_cnt_d = '0;
      filt_d     = clk_s2_q;
    end else begin
      filt_cnt_d = filt_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt_q <= '0;
      filt_q     <= 1'b1;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
    end
  end

  // Data delay line matching the filter latency.
  logic [FILTER_LEN-1:0] dly_q, dly_d;

  always_comb begin
    dly_d[0] = data_s2_q;
  end

  genvar gi;
  generate
    for (gi = 1; gi < FILTER_LEN; gi++) begin : g_dly
      always_comb begin
        dly_d[gi] = dly_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '1;
    end else begin
      dly_q <= dly_d;
    end
  end

  assign clk_level  = filt_q;
  assign data_level = dly_q[FILTER_LEN-1];
`else
  assign clk_level  = clk_s2_q;
  assign data_level = data_s2_q;
`endif

  // Edge detector: previous level 1, current level 0.
  logic clk_prev_q, clk_prev_d;

  always_comb begin
    clk_prev_d = clk_level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_prev_d;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_level;
  assign data_s    = data_level;

endmodule

// File: rtl/ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx
//
// PS/2 receive front end. Deframes 11-bit PS/2 frames (start, 8 data bits
// LSB first, odd parity, stop), exports every good byte raw, and folds the
// E0/F0 prefixes into flags so downstream logic sees one code per key event.
//
// Parameters:
//   TIMEOUT_CYC  clk cycles without a kb_clk falling edge before a partial
//                frame is abandoned
//   FILTER_LEN   glitch filter length (only with PS2_GLITCH_FILTER_EN)
//
// Optional feature: define PS2_GLITCH_FILTER_EN to debounce kb_clk
// (implemented in ps2_sync_filter).
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   kb_clk      in   PS/2 clock (asynchronous)
//   kb_data     in   PS/2 data (asynchronous)
//   raw_byte    out  last good byte, prefixes included
//   raw_valid   out  one-cycle pulse with each raw_byte update
//   code        out  last non-prefix scan code
//   code_break  out  code was preceded by F0
//   code_ext    out  code was preceded by E0
//   code_valid  out  one-cycle pulse when code and flags update
//   parity_err  out  one-cycle pulse on a parity failure
//   frame_err   out  one-cycle pulse on a bad stop bit or a timeout
// ---------------------------------------------------------------------------
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] raw_byte,
  output logic       raw_valid,
  output logic [7:0] code,
  output logic       code_break,
  output logic       code_ext,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic fall_edge;
  logic data_s;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .kb_clk    (kb_clk),
    .kb_data   (kb_data),
    .fall_edge (fall_edge),
    .data_s    (data_s)
  );

  ps2_state_t    state_q,        state_d;
  logic [2:0]    bit_cnt_q,      bit_cnt_d;
  logic [7:0]    shift_q,        shift_d;
  logic          parity_q,       parity_d;
  logic [TW-1:0] tmo_q,          tmo_d;
  logic          break_pend_q,   break_pend_d;
  logic          ext_pend_q,     ext_pend_d;

  logic [7:0]    raw_byte_q,     raw_byte_d;
  logic          raw_valid_q,    raw_valid_d;
  logic [7:0]    code_q,         code_d;
  logic          code_break_q,   code_break_d;
  logic          code_ext_q,     code_ext_d;
  logic          code_valid_q,   code_valid_d;
  logic          parity_err_q,   parity_err_d;
  logic          frame_err_q,    frame_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    raw_byte_d   = raw_byte_q;
    code_d       = code_q;
    code_break_d = code_break_q;
    code_ext_d   = code_ext_q;
    raw_valid_d  = 1'b0;
    code_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A high bit while idle is not a start bit; ignore it silently.
        if (fall_edge && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end

      DATA: begin
        if (fall_edge) begin
          // LSB arrives first, so shifting right leaves bit 0 in place
          // after the eighth bit.
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        if (fall_edge) begin
          parity_d = data_s;
          state_d  = STOP;
        end
      end

      STOP: begin
        if (fall_edge) begin
          state_d = IDLE;
          if (!data_s) begin
            frame_err_d  = 1'b1;
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
            shift_d      = '0;
          end else if (!odd_parity_ok(shift_q, parity_q)) begin
            parity_err_d = 1'b1;
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
            shift_d      = '0;
          end else begin
            raw_byte_d  = shift_q;
            raw_valid_d = 1'b1;
            if (shift_q == PS2_BREAK) begin
              break_pend_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              ext_pend_d = 1'b1;
            end else begin
              code_d       = shift_q;
              code_break_d = break_pend_q;
              code_ext_d   = ext_pend_q;
              code_valid_d = 1'b1;
              break_pend_d = 1'b0;
              ext_pend_d   = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Inter-edge watchdog for partial frames. An edge in the expiry cycle
    // counts as progress, so it is tested first.
    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (fall_edge) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d        = '0;
      state_d      = IDLE;
      frame_err_d  = 1'b1;
      break_pend_d = 1'b0;
      ext_pend_d   = 1'b0;
      shift_d      = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      raw_byte_q   <= '0;
      raw_valid_q  <= 1'b0;
      code_q       <= '0;
      code_break_q <= 1'b0;
      code_ext_q   <= 1'b0;
      code_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
      raw_byte_q   <= raw_byte_d;
      raw_valid_q  <= raw_valid_d;
      code_q       <= code_d;
      code_break_q <= code_break_d;
      code_ext_q   <= code_ext_d;
      code_valid_q <= code_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign raw_byte   = raw_byte_q;
  assign raw_valid  = raw_valid_q;
  assign code       = code_q;
  assign code_break = code_break_q;
  assign code_ext   = code_ext_q;
  assign code_valid = code_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_rx
//
// Directed bench for ps2_scancode_rx. PS/2 frames are driven with a short
// bit period (40 clk cycles) and a 1000-cycle timeout so the whole run stays
// small. A monitor counts output pulses and logs raw bytes; the main
// sequence compares pulse counts and output values against hand-computed
// expectations.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_rx;

  localparam int TIMEOUT_CYC = 1000;

  logic       clk;
  logic       rst;
  logic       kb_clk;
  logic       kb_data;
  logic [7:0] raw_byte;
  logic       raw_valid;
  logic [7:0] code;
  logic       code_break;
  logic       code_ext;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_scancode_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FILTER_LEN  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kb_clk     (kb_clk),
    .kb_data    (kb_data),
    .raw_byte   (raw_byte),
    .raw_valid  (raw_valid),
    .code       (code),
    .code_break (code_break),
    .code_ext   (code_ext),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor (sole writer of these counters) ---------------
  int         raw_cnt    = 0;
  int         code_cnt   = 0;
  int         perr_cnt   = 0;
  int         ferr_cnt   = 0;
  int         overlap_cnt = 0;
  logic [7:0] raw_log [0:63];

  always @(negedge clk) begin
    if (!rst) begin
      if (raw_valid) begin
        raw_log[raw_cnt[5:0]] = raw_byte;
        raw_cnt = raw_cnt + 1;
      end
      if (code_valid) code_cnt = code_cnt + 1;
      if (parity_err) perr_cnt = perr_cnt + 1;
      if (frame_err)  ferr_cnt = ferr_cnt + 1;
      // Error pulses must never coincide with data pulses or each other;
      // code_valid must always ride on a raw_valid.
      if ((parity_err && frame_err) ||
          ((parity_err || frame_err) && (raw_valid || code_valid)) ||
          (code_valid && !raw_valid))
        overlap_cnt = overlap_cnt + 1;
    end
  end

  // ---------------- checking ----------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus helpers --------------------------------------
  // One PS/2 bit: data set while clock high, then a 20-cycle low phase.
  task automatic send_bit(input logic b);
    @(negedge clk);
    kb_data = b;
    repeat (10) @(negedge clk);
    kb_clk = 1'b0;
    repeat (20) @(negedge clk);
    kb_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop_bit);
    kb_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  int raw0, code0, perr0, ferr0;

  task automatic snap();
    raw0  = raw_cnt;
    code0 = code_cnt;
    perr0 = perr_cnt;
    ferr0 = ferr_cnt;
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    rst     = 1'b1;
    kb_clk  = 1'b1;
    kb_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_raw_byte",   32'(raw_byte),   32'h0);
    check("rst_raw_valid",  32'(raw_valid),  32'h0);
    check("rst_code",       32'(code),       32'h0);
    check("rst_code_valid", 32'(code_valid), 32'h0);
    check("rst_code_break", 32'(code_break), 32'h0);
    check("rst_code_ext",   32'(code_ext),   32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);

    // Plain make code 1C
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t1_raw_pulses",  32'(raw_cnt - raw0),   32'd1);
    check("t1_code_pulses", 32'(code_cnt - code0), 32'd1);
    check("t1_raw_byte",    32'(raw_log[raw0[5:0]]), 32'h1C);
    check("t1_code",        32'(code),       32'h1C);
    check("t1_break",       32'(code_break), 32'h0);
    check("t1_ext",         32'(code_ext),   32'h0);

    // Break code F0 1C
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t2_raw_pulses",  32'(raw_cnt - raw0),   32'd2);
    check("t2_raw_first",   32'(raw_log[raw0[5:0]]), 32'hF0);
    check("t2_raw_second",  32'(raw_log[6'(raw0 + 1)]), 32'h1C);
    check("t2_code_pulses", 32'(code_cnt - code0), 32'd1);
    check("t2_code",        32'(code),       32'h1C);
    check("t2_break",       32'(code_break), 32'h1);
    check("t2_ext",         32'(code_ext),   32'h0);

    // Extended break E0 F0 75
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("t3_raw_pulses",  32'(raw_cnt - raw0),   32'd3);
    check("t3_raw_first",   32'(raw_log[raw0[5:0]]), 32'hE0);
    check("t3_code_pulses", 32'(code_cnt - code0), 32'd1);
    check("t3_code",        32'(code),       32'h75);
    check("t3_break",       32'(code_break), 32'h1);
    check("t3_ext",         32'(code_ext),   32'h1);

    // Parity error discards a pending F0; then a clean 32
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t4_perr_pulses", 32'(perr_cnt - perr0), 32'd1);
    check("t4_no_code",     32'(code_cnt - code0), 32'd0);
    check("t4_raw_only_f0", 32'(raw_cnt - raw0),   32'd1);
    check("t4_code_held",   32'(code),       32'h75);
    send_frame(8'h32, 1'b0, 1'b1);
    check("t4_code",        32'(code),       32'h32);
    check("t4_break",       32'(code_break), 32'h0);
    check("t4_ext",         32'(code_ext),   32'h0);

    // Timeout: start + 4 data bits, then the bus stalls high
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    kb_data = 1'b1;
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    check("t5_ferr_pulses", 32'(ferr_cnt - ferr0), 32'd1);
    check("t5_no_raw",      32'(raw_cnt - raw0),   32'd0);
    send_frame(8'h45, 1'b0, 1'b1);
    check("t5_code_pulses", 32'(code_cnt - code0), 32'd1);
    check("t5_code",        32'(code),       32'h45);

    // Reset mid-frame drops a pending F0
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_code",    32'(code),       32'h0);
    repeat (50) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t6_code",        32'(code),       32'h1C);
    check("t6_break",       32'(code_break), 32'h0);

    // Stop bit 0
    snap();
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t7_ferr_pulses", 32'(ferr_cnt - ferr0), 32'd1);
    check("t7_no_raw",      32'(raw_cnt - raw0),   32'd0);
    check("t7_no_code",     32'(code_cnt - code0), 32'd0);

    check("pulse_overlap",  32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 receive front end, directly upstream of keyboard_top's scan-code handling.
- Synchronises kb_clk/kb_data and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop).
- Strips E0/F0 prefixes into flags and presents one clean code per key event.
- Raw bytes are also exported for the sc debug LEDs.

Parameters:
- TIMEOUT_CYC, 200000, clk cycles without a kb_clk falling edge before a partial frame is aborted (2 ms at 100 MHz).
- FILTER_LEN, 8, consecutive stable samples required by the glitch filter (used only with PS2_GLITCH_FILTER_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- kb_clk  in  1  PS/2 clock, asynchronous.
- kb_data  in  1  PS/2 data, asynchronous.
- raw_byte  out  8  last byte received with good parity and stop bit, prefixes included.
- raw_valid  out  1  one-cycle pulse with each raw_byte update.
- code  out  8  last non-prefix scan code.
- code_break  out  1  code was preceded by F0.
- code_ext  out  1  code was preceded by E0.
- code_valid  out  1  one-cycle pulse when code, code_break and code_ext update.
- parity_err  out  1  one-cycle pulse on a parity failure.
- frame_err  out  1  one-cycle pulse on stop bit = 0 or timeout.

Behaviour:
- Reset: all outputs 0; synchronisers load 1 (bus idle high); FSM IDLE; bit counter, timeout counter and prefix flags cleared.
- Reset mid-frame discards the partial frame and any pending prefix flags.
- Input path: 2-FF synchroniser on each input.
- Falling edge = previous synced kb_clk 1 and current 0, evaluated on filtered kb_clk when filtering is enabled. kb_data is sampled in the edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge with data=0, go to DATA and clear bit_cnt. On edge with data=1, stay in IDLE; no error.
  - DATA: on each edge, shift right and insert the bit at [7]. After the 8th bit go to PARITY.
  - PARITY: on edge, store the parity bit and go to STOP.
  - STOP: on edge, go to IDLE and evaluate the frame.
    - Stop bit 0: frame_err.
    - Else, XOR of the 8 data bits and the parity bit must be 1; if not: parity_err.
    - Else: byte accepted.
- Accepted byte: raw_byte, raw_valid, code and flag updates are registered one cycle after the stop-bit edge cycle.
- Prefix handling:
  - 8'hF0 sets break_pend; 8'hE0 sets ext_pend. Both assert raw_valid but not code_valid.
  - Any other accepted byte pulses code_valid with code = byte, code_break = break_pend, code_ext = ext_pend, then clears both pending flags.
- Errors: parity_err or frame_err also clears both pending flags and the shift register. The FSM returns to IDLE.
- Timeout:
  - The counter runs only outside IDLE and restarts on every falling edge.
  - Reaching TIMEOUT_CYC-1 gives a frame_err pulse and a return to IDLE.
  - An edge in the same cycle as expiry wins: the counter restarts and there is no error.
- Output hold: outputs keep their values between pulses. The pulses are exactly one cycle and never overlap each other.
- Widths: the timeout counter is $clog2(TIMEOUT_CYC) bits; bit_cnt is 3 bits.

Optional Feature:
- Macro PS2_GLITCH_FILTER_EN.
- Defined: synced kb_clk passes through a filter that changes its output only after FILTER_LEN consecutive identical samples (counter reset value 0, output reset value 1). This adds FILTER_LEN cycles of latency. kb_data is delayed by matching pipeline stages so sampling alignment is preserved.
- Undefined: synced kb_clk is used directly; no filter logic is present.

Decomposition:
- ps2_pkg holds:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t.
  - Localparams PS2_BREAK = 8'hF0 and PS2_EXT = 8'hE0.
- Sub-module ps2_sync_filter: 2-FF sync plus the optional filter and falling-edge detect; outputs fall_edge and data_s.
- Frame FSM, timeout counter and prefix logic live in ps2_scancode_rx.

Test Plan:
- Frame 0x1C, parity 0, stop 1 (bit period 60 us) → raw_valid and code_valid pulse once; code=8'h1C, code_break=0, code_ext=0.
- F0 then 1C → raw_valid twice (F0, 1C); a single code_valid with code=8'h1C, code_break=1, code_ext=0.
- E0, F0, 75 → three raw_valid pulses; a single code_valid with code=8'h75, code_ext=1, code_break=1.
- 0x1C with parity 1 → parity_err pulse, no code_valid; then a good 0x32 → code=8'h32, flags 0.
- TIMEOUT_CYC=1000: start bit plus 4 data bits, then kb_clk held high for 1000 cycles → frame_err pulse, FSM in IDLE; next frame 0x45 → code=8'h45.
- F0 accepted, rst asserted 1 cycle mid-next-frame, then 0x1C → code_break=0; stop bit 0 on any frame → frame_err, no raw_valid.
